// File: rtl/mul_accum.sv
// Sums N_TERMS unsigned products from the sequential multiplier and presents
// each finished sum on a valid/ready handshake, with a one-entry pending buffer.
//
//   state | meaning
//   ACCUM | collecting products; sum_valid=0
//   HOLD  | finished sum presented; waiting for sum_ready
module mul_accum #(
    parameter int IN_W    = 17,
    parameter int ACC_W   = 20,
    parameter int N_TERMS = 4
) (
    input  logic             ck,
    input  logic             rst,
    input  logic [IN_W-1:0]  prod_in,
    input  logic             prod_fin,
    input  logic             clr,
    output logic [ACC_W-1:0] sum_out,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             ovf,
    output logic             overrun
);

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] TERMS = CNT_W'(N_TERMS);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  count;
    logic [IN_W-1:0]   pend;
    logic              pend_v;

    logic [ACC_W:0]    acc_sum;
    logic              acc_carry;
    logic [ACC_W-1:0]  acc_sat;
    logic [CNT_W-1:0]  count_nxt;

    logic [ACC_W:0]    xfer_sum;
    logic              xfer_carry;
    logic [ACC_W-1:0]  xfer_sat;
    logic [CNT_W-1:0]  xfer_cnt;
    logic              transfer;

    // One extra bit catches the carry; a saturated acc stays all-ones because
    // any further addition also carries out.
    assign acc_sum   = {1'b0, acc} + (ACC_W+1)'(prod_in);
    assign acc_carry = acc_sum[ACC_W];
    assign acc_sat   = acc_carry ? '1 : acc_sum[ACC_W-1:0];
    assign count_nxt = count + 1'b1;

    // On a transfer, the next result starts from whatever was pending plus a
    // product landing in the same cycle.
    assign xfer_sum   = (ACC_W+1)'(pend_v ? pend : '0)
                      + (ACC_W+1)'(prod_fin ? prod_in : '0);
    assign xfer_carry = xfer_sum[ACC_W];
    assign xfer_sat   = xfer_carry ? '1 : xfer_sum[ACC_W-1:0];
    assign xfer_cnt   = CNT_W'(pend_v) + CNT_W'(prod_fin);

    assign transfer = sum_valid & sum_ready;
    assign sum_out  = acc;

    always_ff @(posedge ck) begin
        if (rst || clr) begin
            state     <= ACCUM;
            sum_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            pend      <= '0;
            pend_v    <= 1'b0;
            ovf       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (prod_fin) begin
                        acc   <= acc_sat;
                        ovf   <= ovf | acc_carry;
                        count <= count_nxt;
                        if (count_nxt == TERMS) begin
                            state     <= HOLD;
                            sum_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (transfer) begin
                        acc    <= xfer_sat;
                        ovf    <= xfer_carry;
                        count  <= xfer_cnt;
                        pend_v <= 1'b0;
                        if (xfer_cnt == TERMS) begin
                            state     <= HOLD;
                            sum_valid <= 1'b1;
                        end else begin
                            state     <= ACCUM;
                            sum_valid <= 1'b0;
                        end
                    end else if (prod_fin) begin
                        if (!pend_v) begin
                            pend   <= prod_in;
                            pend_v <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ACCUM;
                    sum_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_accum.sv
// Directed bench for mul_accum: a 20-bit accumulator instance for the main
// flow and a 17-bit instance sharing the same stimulus for saturation.
module tb_mul_accum;

    logic        ck = 1'b0;
    logic        rst;
    logic [16:0] prod_in;
    logic        prod_fin;
    logic        clr;
    logic        sum_ready;

    logic [19:0] sum_a;
    logic        valid_a, ovf_a, overrun_a;
    logic [16:0] sum_b;
    logic        valid_b, ovf_b, overrun_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 ck = ~ck;

    mul_accum #(.IN_W(17), .ACC_W(20), .N_TERMS(4)) dut_a (
        .ck(ck), .rst(rst), .prod_in(prod_in), .prod_fin(prod_fin), .clr(clr),
        .sum_out(sum_a), .sum_valid(valid_a), .sum_ready(sum_ready),
        .ovf(ovf_a), .overrun(overrun_a)
    );

    mul_accum #(.IN_W(17), .ACC_W(17), .N_TERMS(4)) dut_b (
        .ck(ck), .rst(rst), .prod_in(prod_in), .prod_fin(prod_fin), .clr(clr),
        .sum_out(sum_b), .sum_valid(valid_b), .sum_ready(sum_ready),
        .ovf(ovf_b), .overrun(overrun_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    // Products are spaced 9 cycles apart, as the multiplier delivers them.
    task automatic send(input logic [16:0] v);
        repeat (8) step();
        prod_in  = v;
        prod_fin = 1'b1;
        step();
        prod_fin = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; sum_ready = 1'b0;
        prod_in = 17'd5; prod_fin = 1'b1;

        // 1: reset, with prod_fin held high throughout
        step(); step();
        check("rst_sum",     32'(sum_a),     0);
        check("rst_valid",   32'(valid_a),   0);
        check("rst_ovf",     32'(ovf_a),     0);
        check("rst_overrun", 32'(overrun_a), 0);
        rst = 1'b0; prod_fin = 1'b0;
        step();

        // 2: 100+200+300+400, consumer always ready
        sum_ready = 1'b1;
        send(100); send(200); send(300);
        check("t2_valid_before", 32'(valid_a), 0);
        send(400);
        check("t2_valid", 32'(valid_a), 1);
        check("t2_sum",   32'(sum_a),   1000);
        check("t2_ovf",   32'(ovf_a),   0);
        step();
        check("t2_valid_drop", 32'(valid_a), 0);

        // 3: saturation on the 17-bit instance
        send(65025); send(65025); send(65025);
        check("t3_b_ovf_early", 32'(ovf_b), 1);
        send(65025);
        check("t3_b_valid", 32'(valid_b), 1);
        check("t3_b_sum",   32'(sum_b),   131071);
        check("t3_b_ovf",   32'(ovf_b),   1);
        check("t3_a_sum",   32'(sum_a),   260100);
        check("t3_a_ovf",   32'(ovf_a),   0);
        step();
        check("t3_b_ovf_clear", 32'(ovf_b),   0);
        check("t3_b_valid_drop", 32'(valid_b), 0);

        // 4: one product arrives while the result is held
        sum_ready = 1'b0;
        send(1); send(2); send(3); send(4);
        check("t4_valid", 32'(valid_a), 1);
        check("t4_sum",   32'(sum_a),   10);
        send(7);
        check("t4_hold_valid", 32'(valid_a), 1);
        check("t4_hold_sum",   32'(sum_a),   10);
        repeat (3) step();
        sum_ready = 1'b1;
        step();
        check("t4_xfer_valid", 32'(valid_a), 0);
        send(10); send(20); send(30);
        check("t4_next_valid",   32'(valid_a),   1);
        check("t4_next_sum",     32'(sum_a),     67);
        check("t4_overrun",      32'(overrun_a), 0);
        step();

        // 5: two products while held -> overrun, second one lost
        sum_ready = 1'b0;
        send(1); send(1); send(1); send(1);
        check("t5_sum", 32'(sum_a), 4);
        send(50); send(60);
        check("t5_overrun",   32'(overrun_a), 1);
        check("t5_hold_sum",  32'(sum_a),     4);
        sum_ready = 1'b1;
        step();
        check("t5_xfer_valid", 32'(valid_a), 0);
        send(1); send(1);
        sum_ready = 1'b0;
        send(1);
        check("t5_next_sum",     32'(sum_a),     53);
        check("t5_overrun_keep", 32'(overrun_a), 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t5_clr_overrun", 32'(overrun_a), 0);
        check("t5_clr_valid",   32'(valid_a),   0);
        check("t5_clr_sum",     32'(sum_a),     0);
        sum_ready = 1'b1;

        // 6: clr coincident with the 4th product
        send(5); send(5); send(5);
        repeat (8) step();
        prod_in = 17'd5; prod_fin = 1'b1; clr = 1'b1;
        step();
        prod_fin = 1'b0; clr = 1'b0;
        check("t6_valid", 32'(valid_a), 0);
        check("t6_sum",   32'(sum_a),   0);
        send(1); send(2); send(3);
        check("t6_count_valid", 32'(valid_a), 0);
        send(4);
        check("t6_valid_after", 32'(valid_a), 1);
        check("t6_sum_after",   32'(sum_a),   10);
        check("t6_b_sum_after", 32'(sum_b),   10);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
